// File: rtl/fifo_if.sv
// Handshake bundle between a FIFO and its producer/consumer.
// The master side drives strobes and write data; the slave side (the FIFO) returns data and status.
interface fifo_if #(
  parameter int WIDTH = 8
);
  logic             write;
  logic             read;
  logic [WIDTH-1:0] dataIn;
  logic [WIDTH-1:0] dataOut;
  logic             dataPresent;
  logic             halfFull;
  logic             full;

  modport master (
    output write, read, dataIn,
    input  dataOut, dataPresent, halfFull, full
  );

  modport slave (
    input  write, read, dataIn,
    output dataOut, dataPresent, halfFull, full
  );
endinterface

// File: rtl/fifo.sv
// Synchronous first-word fall-through FIFO, DEPTH = 2**LOG2_DEPTH words of WIDTH bits.
// Define FIFO_PROTECT_EN to ignore writes while full and reads while empty.
module fifo #(
  parameter int WIDTH      = 8,
  parameter int LOG2_DEPTH = 4
) (
  input logic   clk,
  input logic   rst,
  fifo_if.slave bus
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] HALF_LEVEL = (LOG2_DEPTH + 1)'(DEPTH / 2);
  localparam logic [LOG2_DEPTH:0] FULL_LEVEL = (LOG2_DEPTH + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wrPtr = '0;
  logic [LOG2_DEPTH-1:0] rdPtr = '0;
  logic [LOG2_DEPTH:0]   count = '0;

  logic empty;
  logic wrAccept;
  logic rdAccept;

  assign empty = (count == '0);

`ifdef FIFO_PROTECT_EN
  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rdAccept = bus.read && !empty;
  assign wrAccept = bus.write && (!bus.full || bus.read);
`else
  // Strobes are trusted, except that a read paired with a write on an empty FIFO is dropped.
  assign rdAccept = bus.read && !(bus.write && empty);
  assign wrAccept = bus.write;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrAccept) wrPtr <= wrPtr + 1'b1;
      if (rdAccept) rdPtr <= rdPtr + 1'b1;
      case ({wrAccept, rdAccept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is never cleared; a reset only abandons its contents.
  always_ff @(posedge clk) begin
    if (!rst && wrAccept) mem[wrPtr] <= bus.dataIn;
  end

  assign bus.dataOut     = mem[rdPtr];
  assign bus.dataPresent = !empty;
  assign bus.halfFull    = (count >= HALF_LEVEL);
  assign bus.full        = (count == FULL_LEVEL);
endmodule

// File: tb/tb_fifo.sv
// Directed testbench for fifo with WIDTH = 8, LOG2_DEPTH = 4.
// Overflow/underflow checks only run when FIFO_PROTECT_EN is defined.
module tb_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   testsRun = 0;
  int   testsFailed = 0;

  fifo_if #(.WIDTH(8)) bus ();

  fifo #(.WIDTH(8), .LOG2_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Drive one clock of stimulus, then return 1 time unit after the edge with strobes idle.
  task automatic applyStimulus(input logic r, input logic w, input logic rd, input logic [7:0] d);
    rst        = r;
    bus.write  = w;
    bus.read   = rd;
    bus.dataIn = d;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.write = 1'b0;
    bus.read  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    bus.write  = 1'b0;
    bus.read   = 1'b0;
    bus.dataIn = 8'h00;

    // Reset state
    doReset();
    doReset();
    checkOutput("resetPresent", {7'd0, bus.dataPresent}, 8'd0);
    checkOutput("resetHalf", {7'd0, bus.halfFull}, 8'd0);
    checkOutput("resetFull", {7'd0, bus.full}, 8'd0);

    // Single write is visible the following cycle
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hA5);
    checkOutput("firstData", bus.dataOut, 8'hA5);
    checkOutput("firstPresent", {7'd0, bus.dataPresent}, 8'd1);
    checkOutput("firstHalf", {7'd0, bus.halfFull}, 8'd0);
    checkOutput("firstFull", {7'd0, bus.full}, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("firstDrained", {7'd0, bus.dataPresent}, 8'd0);

    // Fill to 16 watching halfFull and full thresholds, then drain in order
    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'(i));
      if (i == 6 || i == 7)
        checkOutput($sformatf("halfAfter%0d", i + 1), {7'd0, bus.halfFull}, (i == 7) ? 8'd1 : 8'd0);
      if (i == 14 || i == 15)
        checkOutput($sformatf("fullAfter%0d", i + 1), {7'd0, bus.full}, (i == 15) ? 8'd1 : 8'd0);
    end
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("drain%0d", i), bus.dataOut, 8'(i));
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    end
    checkOutput("drainEmpty", {7'd0, bus.dataPresent}, 8'd0);
    checkOutput("drainNotFull", {7'd0, bus.full}, 8'd0);

`ifdef FIFO_PROTECT_EN
    // Overflow write is dropped, underflow read is dropped
    doReset();
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(i));
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hFF);
    checkOutput("overflowFull", {7'd0, bus.full}, 8'd1);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("overflowDrain%0d", i), bus.dataOut, 8'(i));
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    end
    checkOutput("overflowEmpty", {7'd0, bus.dataPresent}, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("underflowEmpty", {7'd0, bus.dataPresent}, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h44);
    checkOutput("underflowData", bus.dataOut, 8'h44);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("underflowOne", {7'd0, bus.dataPresent}, 8'd0);
`endif

    // Simultaneous read and write with one word held, then on an empty FIFO
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h11);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h22);
    checkOutput("rwOneData", bus.dataOut, 8'h22);
    checkOutput("rwOnePresent", {7'd0, bus.dataPresent}, 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("rwOneDrained", {7'd0, bus.dataPresent}, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h33);
    checkOutput("rwEmptyData", bus.dataOut, 8'h33);
    checkOutput("rwEmptyPresent", {7'd0, bus.dataPresent}, 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("rwEmptyDrained", {7'd0, bus.dataPresent}, 8'd0);

    // Simultaneous read and write while full keeps it full
    doReset();
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h80 + i));
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hEE);
    checkOutput("rwFullFull", {7'd0, bus.full}, 8'd1);
    checkOutput("rwFullData", bus.dataOut, 8'h81);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("rwFullLast", bus.dataOut, 8'hEE);

    // Hold occupancy at three across several pointer wraps
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h43 + i));
      checkOutput($sformatf("wrap%0d", i), bus.dataOut, 8'(8'h40 + i));
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    end
    checkOutput("wrapHalf", {7'd0, bus.halfFull}, 8'd0);

    // Reset mid-operation wins over a concurrent write
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
    checkOutput("preResetPresent", {7'd0, bus.dataPresent}, 8'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h77);
    checkOutput("midResetPresent", {7'd0, bus.dataPresent}, 8'd0);
    checkOutput("midResetHalf", {7'd0, bus.halfFull}, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h5A);
    checkOutput("postResetData", bus.dataOut, 8'h5A);
    checkOutput("postResetPresent", {7'd0, bus.dataPresent}, 8'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, at least 1.
REQ-002 Parameter LOG2_DEPTH, default 4: log2 of storage depth; DEPTH = 2^LOG2_DEPTH; LOG2_DEPTH >= 1.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 write  input  1  write strobe, one clk per word.
REQ-006 read  input  1  read strobe, one clk per word.
REQ-007 dataIn  input  WIDTH  word to write.
REQ-008 dataOut  output  WIDTH  oldest stored word, first-word fall-through.
REQ-009 dataPresent  output  1  high when occupancy > 0.
REQ-010 halfFull  output  1  high when occupancy >= DEPTH/2.
REQ-011 full  output  1  high when occupancy == DEPTH.

Function
REQ-012 Storage SHALL be a DEPTH x WIDTH array with a LOG2_DEPTH-bit write pointer, a LOG2_DEPTH-bit read pointer and a (LOG2_DEPTH+1)-bit occupancy count.
REQ-013 An accepted write SHALL store dataIn at the write pointer, then increment the write pointer modulo DEPTH.
REQ-014 An accepted read SHALL increment the read pointer modulo DEPTH; no data is returned by the strobe itself.
REQ-015 dataOut SHALL be a combinational view of the entry at the read pointer. When dataPresent is high, it is the oldest word, valid with zero latency before read is asserted.
REQ-016 A word written on edge N SHALL appear on dataOut and raise dataPresent after edge N when the FIFO was empty (one-cycle write-to-visible latency).
REQ-017 Occupancy SHALL change as follows: +1 for an accepted write alone; -1 for an accepted read alone; unchanged when both are accepted in the same cycle.
REQ-018 dataPresent, halfFull and full SHALL be decoded combinationally from the registered occupancy.
REQ-019 Simultaneous read and write while empty: the write is accepted, the read is ignored, and occupancy becomes 1.
REQ-020 Simultaneous read and write while full: both are accepted, occupancy stays DEPTH, and the new word goes into the freed slot.
REQ-021 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; ordering is preserved across any number of wraps.
REQ-022 When empty, dataOut SHALL show the stale entry at the read pointer, and consumers SHALL ignore it.

Reset
REQ-023 rst high at a clock edge SHALL clear both pointers and occupancy. Afterwards dataPresent = 0, halfFull = 0 and full = 0.
REQ-024 rst SHALL take priority over simultaneous read and write, which are discarded.
REQ-025 Reset mid-operation SHALL discard all stored words; memory contents are not cleared.
REQ-026 Pointers and occupancy SHALL power up to their reset values without requiring rst.

Configuration
REQ-027 Macro FIFO_PROTECT_EN controls overflow and underflow protection.
- Defined: a write while full SHALL be ignored (contents and pointers unchanged), except as in REQ-020. A read while empty SHALL be ignored.
- Not defined: every write and read strobe SHALL update its pointer and the occupancy unconditionally, with occupancy wrapping modulo 2^(LOG2_DEPTH+1). Overflow and underflow corrupt the contents; avoiding them is the user's responsibility.
- REQ-019 and REQ-020 SHALL hold in both builds.

Verification
REQ-028 Reset, then write 0xA5 for one cycle -> the next cycle shows dataOut = 0xA5, dataPresent = 1, halfFull = 0, full = 0.
REQ-029 WIDTH = 8, LOG2_DEPTH = 4. Write 0x00..0x07 -> halfFull rises after the 8th write. Continue with 0x08..0x0F -> full = 1 after the 16th write. Then read 16 times -> dataOut sequence 0x00..0x0F, dataPresent = 0 after the last read.
REQ-030 FIFO_PROTECT_EN defined, FIFO full: write 0xFF -> occupancy stays 16 and 0xFF never appears on dataOut. FIFO empty: read -> occupancy stays 0.
REQ-031 FIFO holding 1 word 0x11: read and write 0x22 in the same cycle -> dataOut = 0x22 next cycle, occupancy 1. Empty FIFO: read and write 0x33 -> dataOut = 0x33, occupancy 1.
REQ-032 Hold occupancy at 3 with alternating writes and reads for 40 words -> output order matches input order across pointer wrap.
REQ-033 Write 5 words, assert rst for one cycle while write is also high -> dataPresent = 0 and halfFull = 0 afterwards. A subsequent write 0x5A -> dataOut = 0x5A.
